// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - I-cache tag RAM controller: invalidate sweep, tag lookups and line-fill tag writes
module icache_tag_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 8,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          flush_req,
    output logic                                          init_done,
    input  logic                                          lkp_valid,
    output logic                                          lkp_ready,
    input  logic [ADDR_WIDTH-1:0]                         lkp_addr,
    output logic                                          rsp_valid,
    input  logic                                          rsp_ready,
    output logic                                          rsp_hit,
    output logic [INDEX_WIDTH-1:0]                        rsp_index,
    input  logic                                          fill_valid,
    output logic                                          fill_ready,
    input  logic [ADDR_WIDTH-1:0]                         fill_addr,
    output logic                                          tag_wr_en,
    output logic [INDEX_WIDTH-1:0]                        tag_wr_addr,
    output logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH:0]  tag_wr_data,
    output logic [INDEX_WIDTH-1:0]                        tag_rd_addr,
    input  logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH:0]  tag_rd_data
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR,
        S_RD,
        S_RSP
    } state_t;

    state_t                   state, state_d;
    logic [INDEX_WIDTH-1:0]   cnt, cnt_d;
    logic                     flush_pend, flush_pend_d;
    logic                     init_done_d;
    logic                     wr_en_d;
    logic [INDEX_WIDTH-1:0]   wr_addr_d;
    logic [TAG_WIDTH:0]       wr_data_d;
    logic [TAG_WIDTH-1:0]     lat_tag, lat_tag_d;
    logic [INDEX_WIDTH-1:0]   lat_index, lat_index_d;
    logic                     rsp_valid_d;
    logic                     rsp_hit_d;

    logic [TAG_WIDTH-1:0]     lkp_tag, fill_tag;
    logic [INDEX_WIDTH-1:0]   lkp_index, fill_index;
    logic                     unused_offset_bits;

    assign lkp_tag    = lkp_addr[ADDR_WIDTH-1:TAG_LSB];
    assign lkp_index  = lkp_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign fill_tag   = fill_addr[ADDR_WIDTH-1:TAG_LSB];
    assign fill_index = fill_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign unused_offset_bits = ^{lkp_addr[OFFSET_WIDTH-1:0], fill_addr[OFFSET_WIDTH-1:0]};

    // The responded index is the one latched at lookup acceptance; it is stable through RD and RSP.
    assign rsp_index = lat_index;

    // Next-state and handshake decode; RAM write port values are computed here and registered below.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        flush_pend_d = flush_pend | flush_req;
        init_done_d  = init_done;
        wr_en_d      = 1'b0;
        wr_addr_d    = tag_wr_addr;
        wr_data_d    = tag_wr_data;
        lat_tag_d    = lat_tag;
        lat_index_d  = lat_index;
        rsp_valid_d  = rsp_valid;
        rsp_hit_d    = rsp_hit;
        lkp_ready    = 1'b0;
        fill_ready   = 1'b0;
        tag_rd_addr  = lat_index;

        case (state)
            S_INIT: begin
                // A flush arriving mid-sweep simply restarts the sweep, so it is absorbed here.
                flush_pend_d = 1'b0;
                if (flush_req) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                    cnt_d     = INDEX_WIDTH'(1);
                end else if (tag_wr_en && (tag_wr_addr == {INDEX_WIDTH{1'b1}})) begin
                    // Last index is on the write port this cycle: stop without a wrap write.
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt;
                    wr_data_d = '0;
                    cnt_d     = cnt + INDEX_WIDTH'(1);
                end
            end
            S_IDLE: begin
                tag_rd_addr = lkp_index;
                if (flush_pend) begin
                    flush_pend_d = 1'b0;
                    init_done_d  = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_INIT;
                end else begin
                    fill_ready = 1'b1;
                    lkp_ready  = ~fill_valid;
                    if (fill_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = fill_index;
                        wr_data_d = {1'b1, fill_tag};
                        state_d   = S_WR;
                    end else if (lkp_valid) begin
                        lat_tag_d   = lkp_tag;
                        lat_index_d = lkp_index;
                        state_d     = S_RD;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD: begin
                rsp_hit_d   = tag_rd_data[TAG_WIDTH] & (tag_rd_data[TAG_WIDTH-1:0] == lat_tag);
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, sweep counter, latched lookup and registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            cnt         <= '0;
            flush_pend  <= 1'b0;
            init_done   <= 1'b0;
            tag_wr_en   <= 1'b0;
            tag_wr_addr <= '0;
            tag_wr_data <= '0;
            lat_tag     <= '0;
            lat_index   <= '0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            flush_pend  <= flush_pend_d;
            init_done   <= init_done_d;
            tag_wr_en   <= wr_en_d;
            tag_wr_addr <= wr_addr_d;
            tag_wr_data <= wr_data_d;
            lat_tag     <= lat_tag_d;
            lat_index   <= lat_index_d;
            rsp_valid   <= rsp_valid_d;
            rsp_hit     <= rsp_hit_d;
        end
    end
endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - self-checking bench for icache_tag_ctrl with a behavioural tag SDPRAM
module tb_icache_tag_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_req, init_done;
    logic        lkp_valid, lkp_ready;
    logic [31:0] lkp_addr;
    logic        rsp_valid, rsp_ready, rsp_hit;
    logic [7:0]  rsp_index;
    logic        fill_valid, fill_ready;
    logic [31:0] fill_addr;
    logic        tag_wr_en;
    logic [7:0]  tag_wr_addr, tag_rd_addr;
    logic [20:0] tag_wr_data, tag_rd_data;

    always #5 clk = ~clk;

    icache_tag_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .init_done(init_done),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .tag_wr_en(tag_wr_en), .tag_wr_addr(tag_wr_addr), .tag_wr_data(tag_wr_data),
        .tag_rd_addr(tag_rd_addr), .tag_rd_data(tag_rd_data)
    );

    // Tag SDPRAM: unwritten entries read as 21'h1FFFFF, registered read, old data on same-cycle collision.
    logic [20:0] ram [256];
    bit          wr_seen [256];
    always @(posedge clk) begin
        if (tag_wr_en) begin
            ram[tag_wr_addr]     <= tag_wr_data;
            wr_seen[tag_wr_addr] <= 1'b1;
        end
        tag_rd_data <= wr_seen[tag_rd_addr] ? ram[tag_rd_addr] : 21'h1FFFFF;
    end

    // Shared between stimulus (writer) and checker (reader).
    logic [8:0] lit_exp [0:31];
    int         lit_n   = 0;
    int         tmo_req = 0;
    bit         end_req = 1'b0;

    // Checker state.
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         acc_cyc = -10;
    int         lit_rd = 0;
    int         tmo_seen = 0;
    int         sweep_next = 0;
    int         idx;
    bit         sweeping = 1'b0, sweep_expected = 1'b1, done_due = 1'b0, fill_wr_due = 1'b0;
    bit         busy, end_ack = 1'b0;
    bit         model_v [256];
    logic [19:0] model_t [256];
    logic [7:0] fw_addr;
    logic [20:0] fw_data;
    logic [8:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the cache-level model.
    always @(negedge clk) begin
        cyc++;
        if (tmo_req != tmo_seen) begin
            chk("wait_timeout", 64'(tmo_req), 64'(tmo_seen));
            tmo_seen = tmo_req;
        end
        if (!rst_n) begin
            chk("reset_outputs", {init_done, lkp_ready, fill_ready, rsp_valid, tag_wr_en}, 0);
            for (int i = 0; i < 256; i++) model_v[i] = 1'b0;
            exp_q.delete();
            sweeping = 1'b0; sweep_expected = 1'b1; sweep_next = 0;
            done_due = 1'b0; fill_wr_due = 1'b0;
        end else begin
            busy = sweep_expected || sweeping || (exp_q.size() != 0) || fill_wr_due;
            if (busy) chk("ready_blocked", {lkp_ready, fill_ready}, 0);
            if (fill_valid) chk("fill_priority", lkp_ready, 0);

            if (done_due) begin
                chk("init_done_after_sweep", {init_done, tag_wr_en}, 2'b10);
                done_due = 1'b0;
            end else if (sweeping || (tag_wr_en && sweep_expected && tag_wr_data == 21'h0)) begin
                chk("sweep_write", {tag_wr_en, tag_wr_data, init_done, tag_wr_addr},
                    {1'b1, 21'h0, 1'b0, sweep_next[7:0]});
                sweeping = 1'b1; sweep_expected = 1'b0;
                sweep_next++;
                if (sweep_next == 256) begin
                    sweeping = 1'b0;
                    done_due = 1'b1;
                end
            end else if (fill_wr_due) begin
                chk("fill_write", {tag_wr_en, tag_wr_addr, tag_wr_data}, {1'b1, fw_addr, fw_data});
                fill_wr_due = 1'b0;
            end else begin
                chk("no_stray_write", tag_wr_en, 0);
            end

            if (exp_q.size() != 0 && cyc == acc_cyc + 2) chk("rsp_latency", rsp_valid, 1);
            if (rsp_valid) begin
                chk("rsp_expected", (exp_q.size() != 0) && (cyc >= acc_cyc + 2), 1);
                if (exp_q.size() != 0) begin
                    chk("rsp_fields", {rsp_hit, rsp_index}, exp_q[0]);
                    chk("rsp_hold_quiet", {tag_wr_en, tag_rd_addr}, {1'b0, exp_q[0][7:0]});
                    if (rsp_ready) begin
                        if (lit_rd < lit_n) chk("rsp_literal", {rsp_hit, rsp_index}, lit_exp[lit_rd]);
                        lit_rd++;
                        void'(exp_q.pop_front());
                    end
                end
            end

            if (fill_valid && fill_ready) begin
                idx = int'(fill_addr[11:4]);
                model_v[idx] = 1'b1;
                model_t[idx] = fill_addr[31:12];
                fill_wr_due  = 1'b1;
                fw_addr      = fill_addr[11:4];
                fw_data      = {1'b1, fill_addr[31:12]};
            end
            if (lkp_valid && lkp_ready) begin
                idx = int'(lkp_addr[11:4]);
                exp_q.push_back({model_v[idx] && (model_t[idx] == lkp_addr[31:12]), lkp_addr[11:4]});
                acc_cyc = cyc;
                chk("lkp_rd_addr", tag_rd_addr, lkp_addr[11:4]);
            end
            if (flush_req) begin
                for (int i = 0; i < 256; i++) model_v[i] = 1'b0;
                sweep_expected = 1'b1;
                sweep_next = 0;
            end
        end
        if (end_req && !end_ack) begin
            chk("all_responses", 64'(lit_rd), 64'(lit_n));
            chk("queue_drained", 64'(exp_q.size()), 0);
            end_ack = 1'b1;
        end
    end

    task automatic wait_init();
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (init_done) break;
        end
        if (k == 600) tmo_req++;
    endtask

    task automatic wait_init_low();
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!init_done) break;
        end
        if (k == 40) tmo_req++;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a);
        int k;
        @(posedge clk); #1;
        fill_valid = 1'b1; fill_addr = a;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fill_ready) break;
        end
        if (k == 20) tmo_req++;
        @(posedge clk); #1 fill_valid = 1'b0;
    endtask

    // Complete a lookup already presented on lkp_valid/lkp_addr, then consume its response.
    task automatic finish_lookup(input int hold, input bit flush);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lkp_ready) break;
        end
        if (k == 20) tmo_req++;
        @(posedge clk); #1 lkp_valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (k == 20) tmo_req++;
        if (flush) begin
            @(posedge clk); #1 flush_req = 1'b1;
            @(posedge clk); #1 flush_req = 1'b0;
        end
        repeat (hold) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_lookup(input logic [31:0] a, input logic [8:0] lit, input int hold, input bit flush);
        lit_exp[lit_n] = lit;
        lit_n++;
        @(posedge clk); #1;
        lkp_valid = 1'b1; lkp_addr = a; rsp_ready = (hold == 0);
        finish_lookup(hold, flush);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; flush_req = 1'b0; lkp_valid = 1'b0; lkp_addr = '0;
        rsp_ready = 1'b1; fill_valid = 1'b0; fill_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();

        do_lookup(32'h0000_1234, 9'h023, 0, 1'b0);
        do_fill(32'h0000_1230);
        do_lookup(32'h0000_123C, 9'h123, 0, 1'b0);
        do_lookup(32'h0001_1230, 9'h023, 0, 1'b0);

        lit_exp[lit_n] = 9'h134;
        lit_n++;
        @(posedge clk); #1;
        fill_valid = 1'b1; fill_addr = 32'h0000_2340;
        lkp_valid  = 1'b1; lkp_addr  = 32'h0000_2344; rsp_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fill_ready) break;
        end
        if (k == 20) tmo_req++;
        @(posedge clk); #1 fill_valid = 1'b0;
        finish_lookup(0, 1'b0);

        do_lookup(32'h0000_2348, 9'h134, 5, 1'b0);

        do_lookup(32'h0000_1230, 9'h123, 2, 1'b1);
        wait_init_low();
        wait_init();
        do_lookup(32'h0000_1230, 9'h023, 0, 1'b0);
        do_lookup(32'h0000_2344, 9'h034, 0, 1'b0);
        do_lookup(32'hFFFF_FFF0, 9'h0FF, 0, 1'b0);

        pulse_flush();
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (tag_wr_en && tag_wr_addr == 8'd100) break;
        end
        if (k == 600) tmo_req++;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();
        do_lookup(32'hFFFF_FFF4, 9'h0FF, 0, 1'b0);
        do_lookup(32'h0000_1230, 9'h023, 0, 1'b0);
        do_fill(32'hFFFF_FFF0);
        do_lookup(32'hFFFF_FFFC, 9'h1FF, 0, 1'b0);

        repeat (3) @(posedge clk);
        end_req = 1'b1;
        for (k = 0; k < 10; k++) begin
            @(posedge clk);
            if (end_ack) break;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
